kpn_fifo_channel: RTL and testbench
===================================

Name: kpn_fifo_channel

Overview:
- Parametrised KPN channel FIFO: single clock, with synchronous reset, occupancy count and almost-full flag.
- Supports simultaneous read and write in one cycle.
- Read data is registered and comes with a one-cycle valid strobe.
- Sits between KPN process modules as the blocking point-to-point channel: producers stall on full, consumers stall on empty.

Parameters:
- BITS_NUMBER, 16: data word width in bits.
- FIFO_ELEMENTS, 5: log2 of depth; DEPTH = 2**FIFO_ELEMENTS.
- AF_THRESH, 2**FIFO_ELEMENTS-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- wr, input, 1: write request.
- entry_1, input, BITS_NUMBER: write data.
- rd, input, 1: read request.
- output_1, output, BITS_NUMBER: registered read data.
- output_valid, output, 1: high for one cycle when output_1 was updated by an accepted read.
- full, output, 1: count == DEPTH.
- almost_full, output, 1: count >= AF_THRESH.
- empty, output, 1: count == 0.
- count, output, FIFO_ELEMENTS+1: current occupancy, 0..DEPTH.

Behaviour:
- Single clock domain; one clk, sampled on its rising edge.
- Reset is synchronous and active-high and overrides rd/wr in the same cycle. Reset values:
  - write pointer 0, read pointer 0, count 0
  - empty 1, full 0, almost_full 0 (0 even when AF_THRESH is small, since count is 0)
  - output_1 0, output_valid 0
  - storage array is not cleared.
- Accept rules use the registered flags of the current cycle:
  - wr_acc = wr & ~full
  - rd_acc = rd & ~empty
- Write: on wr_acc, store entry_1 at the write pointer and increment the write pointer modulo DEPTH (natural wrap of the FIFO_ELEMENTS-bit pointer).
- Read:
  - On rd_acc, output_1 <= array[read pointer] at the same edge, the read pointer increments modulo DEPTH, and output_valid <= 1.
  - Otherwise output_valid <= 0 and output_1 holds its value.
  - Read latency: data is visible the cycle after rd is sampled.
- Count update:
  - wr_acc & ~rd_acc: count + 1
  - rd_acc & ~wr_acc: count - 1
  - both or neither: unchanged
- Flags are registered, derived from next count, and update on the same edge as count.
- Simultaneous rd & wr:
  - not empty and not full: both accepted; count unchanged; the read returns the oldest word, never the word being written.
  - empty: write accepted, read rejected (no fall-through); output_valid 0; count becomes 1.
  - full: read accepted, write rejected and dropped; count becomes DEPTH-1.
- Rejected requests have no side effects: no pointer, count or data change.
- Reset asserted mid-stream empties the FIFO in one cycle. Words written before reset are never read after it.
- No combinational path from rd/wr to any output.

Optional Feature:
- Macro KPN_FIFO_ERR_EN.
- When defined:
  - Adds input err_clear (1) and outputs overflow (1) and underflow (1).
  - overflow sets sticky on wr & full; underflow sets sticky on rd & empty.
  - Both clear on reset or err_clear; set has priority over err_clear in the same cycle.
- When undefined:
  - These three ports do not exist.
  - Rejected requests are silently dropped; core behaviour is identical.

Test Plan:
All scenarios use BITS_NUMBER=16, FIFO_ELEMENTS=2 (DEPTH 4), AF_THRESH=3.
- Reset then idle: count=0, empty=1, full=0, almost_full=0, output_1=0x0000, output_valid=0.
- Fill: write 0x1111, 0x2222, 0x3333, 0x4444 in consecutive cycles.
  - almost_full rises after the 3rd write; full rises after the 4th; count=4.
  - A 5th write of 0x5555 is dropped; count stays 4; overflow=1 when KPN_FIFO_ERR_EN is defined.
- Drain: rd held high for 5 cycles.
  - output_1 = 0x1111, 0x2222, 0x3333, 0x4444 on successive cycles with output_valid=1.
  - 5th read rejected: output_valid=0, output_1 holds 0x4444, empty=1; underflow=1 when KPN_FIFO_ERR_EN is defined.
- Wrap-around: 10 cycles of simultaneous rd & wr of an incrementing value starting from count=2 (contents 0xA000, 0xA001).
  - Count stays 2; outputs appear in order 0xA000, 0xA001, 0x0000, 0x0001, ...
  - Pointers wrap past 3 without loss.
- Simultaneous rd & wr when empty: write 0xBEEF is accepted, read is rejected, output_valid=0, count=1. Next-cycle read returns 0xBEEF.
- Reset mid-operation with count=3 while rd=1 & wr=1: next cycle count=0, empty=1, output_valid=0. A following read is rejected.

Source files
------------

// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: blocking KPN channel FIFO with registered read data, count and almost-full; optional error flags via KPN_FIFO_ERR_EN
module kpn_fifo_channel #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5,
  parameter int AF_THRESH     = 2**FIFO_ELEMENTS-2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [BITS_NUMBER-1:0]   entry_1,
  input  logic                     rd,
  output logic [BITS_NUMBER-1:0]   output_1,
  output logic                     output_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [FIFO_ELEMENTS:0]   count
`ifdef KPN_FIFO_ERR_EN
  ,
  input  logic                     err_clear,
  output logic                     overflow,
  output logic                     underflow
`endif
);
  localparam int DEPTH = 2**FIFO_ELEMENTS;
  localparam logic [FIFO_ELEMENTS:0] DEPTH_W = DEPTH[FIFO_ELEMENTS:0];
  localparam logic [FIFO_ELEMENTS:0] AF_W = AF_THRESH[FIFO_ELEMENTS:0];
  logic [BITS_NUMBER-1:0] mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] wp, rp;
  logic wr_acc, rd_acc;
  logic [FIFO_ELEMENTS:0] count_n;
  always_comb begin
    wr_acc = wr & ~full;
    rd_acc = rd & ~empty;
    count_n = (wr_acc && !rd_acc) ? count + 1'b1 : (rd_acc && !wr_acc) ? count - 1'b1 : count;
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (!reset && wr_acc) mem[wp] <= entry_1;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_full <= 1'b0;
      output_1 <= '0;
      output_valid <= 1'b0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) begin
        rp <= rp + 1'b1;
        output_1 <= mem[rp];
      end
      output_valid <= rd_acc;
      count <= count_n;
      empty <= count_n == '0;
      full <= count_n == DEPTH_W;
      almost_full <= count_n >= AF_W;
    end
  end
`ifdef KPN_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (wr & full) | (overflow & ~err_clear);
      underflow <= (rd & empty) | (underflow & ~err_clear);
    end
  end
`endif
endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb_kpn_fifo_channel: directed table plus randomized traffic against a queue model of the channel
module tb_kpn_fifo_channel;
  localparam int W = 16;
  localparam int FE = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  logic clk = 1'b0;
  logic reset, wr, rd;
  logic [W-1:0] entry_1, output_1;
  logic output_valid, full, almost_full, empty;
  logic [FE:0] count;
  logic ec;
`ifdef KPN_FIFO_ERR_EN
  logic overflow, underflow;
`endif
  kpn_fifo_channel #(.BITS_NUMBER(W), .FIFO_ELEMENTS(FE), .AF_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .wr(wr), .entry_1(entry_1), .rd(rd),
    .output_1(output_1), .output_valid(output_valid), .full(full),
    .almost_full(almost_full), .empty(empty), .count(count)
`ifdef KPN_FIFO_ERR_EN
    , .err_clear(ec), .overflow(overflow), .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_out = '0;
  logic m_val = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic w, input logic rr, input logic [W-1:0] d, input logic c);
    int n;
    reset = r; wr = w; rd = rr; entry_1 = d; ec = c;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      m_out = '0; m_val = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = (w && n == DEPTH) || (m_ovf && !c);
      m_unf = (rr && n == 0) || (m_unf && !c);
      m_val = rr && n > 0;
      if (m_val) m_out = q.pop_front();
      if (w && n < DEPTH) q.push_back(d);
    end
    #1;
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_af", 32'(almost_full), 32'(q.size() >= AF));
    chk("m_valid", 32'(output_valid), 32'(m_val));
    chk("m_out", 32'(output_1), 32'(m_out));
`ifdef KPN_FIFO_ERR_EN
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
`endif
  endtask
  typedef struct {
    logic r, w, rd;
    logic [W-1:0] d;
    int cnt;
    logic [W-1:0] out;
    logic v, e, f, a;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, input logic w, input logic rr, input logic [W-1:0] d,
                     input int cnt, input logic [W-1:0] out, input logic v, input logic e, input logic f, input logic a);
    vec_t t;
    t.r = r; t.w = w; t.rd = rr; t.d = d; t.cnt = cnt; t.out = out; t.v = v; t.e = e; t.f = f; t.a = a;
    tbl.push_back(t);
  endtask
  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; entry_1 = '0; ec = 1'b0;
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 0, 16'h1111, 1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 16'h2222, 2, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 16'h3333, 3, 16'h0000, 0, 0, 0, 1);
    add(0, 1, 0, 16'h4444, 4, 16'h0000, 0, 0, 1, 1);
    add(0, 1, 0, 16'h5555, 4, 16'h0000, 0, 0, 1, 1);
    add(0, 0, 1, 16'h0000, 3, 16'h1111, 1, 0, 0, 1);
    add(0, 0, 1, 16'h0000, 2, 16'h2222, 1, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 1, 16'h3333, 1, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h4444, 1, 1, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h4444, 0, 1, 0, 0);
    add(0, 1, 1, 16'hBEEF, 1, 16'h4444, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 16'hBEEF, 1, 1, 0, 0);
    add(0, 1, 0, 16'hA000, 1, 16'hBEEF, 0, 0, 0, 0);
    add(0, 1, 0, 16'hA001, 2, 16'hBEEF, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 1, 1, 16'(k), 2, (k < 2) ? 16'(16'hA000 + k) : 16'(k - 2), 1, 0, 0, 0);
    add(0, 1, 0, 16'hC000, 3, 16'h0007, 0, 0, 0, 1);
    add(1, 1, 1, 16'hDEAD, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].d, 1'b0);
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_out", i), 32'(output_1), 32'(tbl[i].out));
      chk($sformatf("t%0d_valid", i), 32'(output_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d_flags", i), {29'd0, empty, full, almost_full}, {29'd0, tbl[i].e, tbl[i].f, tbl[i].a});
`ifdef KPN_FIFO_ERR_EN
      if (i == 6) chk("ovf_after_5th_write", 32'(overflow), 32'd1);
      if (i == 11) chk("unf_after_5th_read", 32'(underflow), 32'd1);
`endif
    end
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(99) < 55, $urandom_range(99) < 50,
          16'($urandom), $urandom_range(15) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
